// File: rtl/kbd_display_scan_ctrl.sv
// kbd_display_scan_ctrl: PS/2 set-2 parser keeping the last 4 make codes and scanning them onto 4 muxed 7-seg digits.
// Optional typematic-repeat suppression is compiled in with `define AUTOREPEAT_FILTER_EN.
module kbd_display_scan_ctrl #(
  parameter int          REFRESH_CNT = 50000,
  parameter logic [7:0]  BREAK_CODE  = 8'hF0,
  parameter logic [7:0]  EXT_CODE    = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  input  logic       clr,
  output logic [7:0] scan_sel,
  input  logic [6:0] seg_in,
  output logic [6:0] seg_out,
  output logic [3:0] an,
  output logic       key_pulse
);
  localparam int CW = $clog2(REFRESH_CNT);
  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;
  state_t          state, state_nx;
  logic [7:0]      hist [4];
  logic [3:0]      slot_vld;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            rep;
`ifdef AUTOREPEAT_FILTER_EN
  logic [7:0]      held;
  logic            held_vld;
  assign rep = held_vld && code_in == held;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      held     <= 8'h00;
      held_vld <= 1'b0;
    end else if (push) begin
      held     <= code_in;
      held_vld <= 1'b1;
    end else if (code_valid && state == S_BRK && rep) begin
      held_vld <= 1'b0;
    end
  end
`else
  assign rep = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    if (clr) begin
      state_nx = S_IDLE;
    end else if (code_valid) begin
      case (state)
        S_IDLE: begin
          state_nx = code_in == BREAK_CODE ? S_BRK : code_in == EXT_CODE ? S_EXT : S_IDLE;
          push     = code_in != BREAK_CODE && code_in != EXT_CODE && !rep;
        end
        S_EXT:   state_nx = code_in == BREAK_CODE ? S_EXT_BRK : S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
      slot_vld  <= 4'b0000;
      key_pulse <= 1'b0;
    end else begin
      if (push) begin
        hist[3]  <= hist[2];
        hist[2]  <= hist[1];
        hist[1]  <= hist[0];
        hist[0]  <= code_in;
        slot_vld <= {slot_vld[2:0], 1'b1};
      end
      key_pulse <= push;
    end
  end
  assign scan_sel = hist[idx];
  // an and seg_out share one register stage so digit select and pattern never skew
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      an      <= 4'hF;
      seg_out <= 7'h7F;
    end else begin
      cnt     <= cnt == CW'(REFRESH_CNT - 1) ? '0 : cnt + 1'b1;
      idx     <= cnt == CW'(REFRESH_CNT - 1) ? idx + 2'd1 : idx;
      an      <= ~(4'b0001 << idx);
      seg_out <= slot_vld[idx] ? seg_in : 7'h7F;
    end
  end
endmodule
